fcl_arbiter: RTL and testbench
==============================

# fcl_arbiter

Parametrised field-config-load (FCL) controller. It accepts rising-edge load commands on N_CFG channels, arbitrates them and holds one pending request. It presents the selected configuration index and issues a one-cycle go strobe once loading is allowed, then tracks the loader's busy window. It sits between the debounced button/command layer and the field loader, replacing the fixed two-config controller.

## Interface
- N_CFG, 4: number of loadable configurations (≥1).
- TIMEOUT_CYC, 1024: max cycles to wait for i_is_loading to rise after o_go (≥2).
- IDX_W, localparam $clog2(N_CFG+1): index width.

- clk  in  1  system clock.
- rst  in  1  reset: synchronous and active-high.
- i_cmd_load_cfg  in  N_CFG  level commands; bit k requests config k.
- i_FCL_allowed  in  1  loader may start a new load.
- i_is_loading  in  1  loader busy.
- o_go  out  1  one-cycle start strobe.
- o_cur_cfg_idx  out  IDX_W  0 = none; k+1 = config k.
- o_busy  out  1  FSM not IDLE.
- o_timeout  out  1  one-cycle pulse, load never started.

## Operation
- Edge detect: cmd_prev register; edge = i_cmd_load_cfg & ~cmd_prev. Held commands never re-trigger.
- Arbitration: among simultaneous edges, the lowest bit index wins; the others are dropped.
- States:
  - IDLE: idx=0. Pending valid → ARMED with pending idx, pending cleared. Else edge → ARMED with edge idx. Pending takes precedence; a same-cycle edge goes into the pending slot.
  - ARMED: idx shown, o_go=0. A new edge replaces idx, because no load has been issued. i_FCL_allowed=1 → GO.
  - GO: o_go=1 for exactly one cycle → WAIT_START, unconditionally.
  - WAIT_START: i_is_loading=1 → LOADING. Timeout behaviour is set by the macro under Configuration.
  - LOADING: i_is_loading=0 → IDLE. idx is cleared on that same transition.
- Pending slot: one entry. An edge in GO, WAIT_START or LOADING writes it; the latest edge overwrites.
- Outputs are registered Moore outputs. o_busy = (state != IDLE).

## Timing
- Reset: state=IDLE, o_go=0, o_cur_cfg_idx=0, o_busy=0, o_timeout=0, pending cleared, cmd_prev=all ones. A command held through reset is ignored until released and re-pressed.
- Reset mid-operation aborts everything on the next edge, including a pending request. No o_go or o_timeout is produced.
- Edge sampled at posedge k in IDLE: idx and o_busy valid after posedge k.
- i_FCL_allowed sampled high at posedge k+1: o_go high between posedges k+2 and k+3. If allowed is already high, the minimum edge-to-go latency is 2 cycles.
- i_is_loading must be seen high at least once after GO. A high level during GO itself is not used.
- i_is_loading falls at posedge m: idx=0 and o_busy=0 after posedge m. A pending request re-arms at posedge m+1.
- i_FCL_allowed dropping in ARMED: wait, no error.

## Configuration
- FCL_TIMEOUT_EN defined:
  - Counter of width $clog2(TIMEOUT_CYC+1) clears on entering WAIT_START.
  - If TIMEOUT_CYC consecutive WAIT_START cycles pass with i_is_loading=0 → IDLE, idx=0, o_timeout=1 for one cycle.
  - i_is_loading=1 in the expiry cycle wins: → LOADING, no timeout.
- FCL_TIMEOUT_EN undefined: WAIT_START waits indefinitely, o_timeout tied 0, no counter logic.

## Structure
- Package defs: fcl_arb_state_t enum (IDLE, ARMED, GO, WAIT_START, LOADING) and constant FCL_NO_CFG = 0.
- Sub-module fcl_cmd_edge_arb: cmd_prev register, edge detect and lowest-index priority encoder. Outputs edge_valid and edge_idx (1-based). The FSM, pending slot and timeout live in the top module.

## Test plan
- Reset, then bit 1 held across rst deassert → no request; release and re-press with allowed=1 → idx=2, o_go one cycle two cycles after the edge.
- Edges on bits 2 and 0 in the same cycle → idx=1. Loading pulse of 3 cycles → idx=0 and busy=0 after the falling edge.
- Allowed=0, edge bit 0, then edge bit 3 while ARMED → idx=4. Raise allowed → exactly one o_go.
- During LOADING of cfg 1, edges on bit 2 then bit 3 → after load end, re-arm with idx=4 and a second o_go.
- FCL_TIMEOUT_EN, TIMEOUT_CYC=8, i_is_loading never rises → o_timeout one cycle, 8 cycles after leaving GO, idx=0. Repeat with is_loading rising in the 8th cycle → LOADING, no timeout.
- Assert rst during WAIT_START with a request pending → all outputs 0 next cycle, no later o_go.

Source files
------------

// File: rtl/fcl_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fcl_arbiter_pkg                                              |
// | Purpose : Shared types and constants for the field-config-load         |
// |           arbiter: controller state enum and the "no config" index.    |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package fcl_arbiter_pkg;

  // Controller states. WAIT_START waits for the loader to report busy
  // after the go strobe; LOADING tracks the loader's busy window.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    GO         = 3'd2,
    WAIT_START = 3'd3,
    LOADING    = 3'd4
  } fcl_arb_state_t;

  // Index value meaning "no configuration selected"; config k is k+1.
  localparam int FCL_NO_CFG = 0;

endpackage : fcl_arbiter_pkg
`default_nettype wire

// File: rtl/fcl_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fcl_arbiter_if                                               |
// | Purpose : Bundles the command/loader handshake of fcl_arbiter.         |
// | Ports   : i_cmd_load_cfg [N_CFG] - level load commands                 |
// |           i_FCL_allowed          - loader may start a new load         |
// |           i_is_loading           - loader busy                         |
// |           o_go                   - one-cycle start strobe              |
// |           o_cur_cfg_idx [IDX_W]  - 0 none, k+1 = config k              |
// |           o_busy                 - controller not idle                 |
// |           o_timeout              - one-cycle "load never started"      |
// |           modport slave  : arbiter side                                |
// |           modport master : command/loader side                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface fcl_arbiter_if #(
  parameter int N_CFG = 4
);
  localparam int IDX_W = $clog2(N_CFG + 1);

  logic [N_CFG-1:0] i_cmd_load_cfg;
  logic             i_FCL_allowed;
  logic             i_is_loading;
  logic             o_go;
  logic [IDX_W-1:0] o_cur_cfg_idx;
  logic             o_busy;
  logic             o_timeout;

  modport slave (
    input  i_cmd_load_cfg, i_FCL_allowed, i_is_loading,
    output o_go, o_cur_cfg_idx, o_busy, o_timeout
  );

  modport master (
    output i_cmd_load_cfg, i_FCL_allowed, i_is_loading,
    input  o_go, o_cur_cfg_idx, o_busy, o_timeout
  );
endinterface : fcl_arbiter_if
`default_nettype wire

// File: rtl/fcl_arbiter_cmd_edge_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fcl_cmd_edge_arb                                             |
// | Purpose : Rising-edge detect on the load command bits followed by a    |
// |           lowest-index-wins priority encoder.                          |
// | Ports   : clk, rst      - clock, synchronous active-high reset         |
// |           cmd_i         - level commands, bit k requests config k      |
// |           edge_valid_o  - at least one new press this cycle            |
// |           edge_idx_o    - winning press, 1-based (0 when none)         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module fcl_cmd_edge_arb #(
  parameter int N_CFG = 4
) (
  input  wire                          clk,
  input  wire                          rst,
  input  wire  [N_CFG-1:0]             cmd_i,
  output logic                         edge_valid_o,
  output logic [$clog2(N_CFG+1)-1:0]   edge_idx_o
);
  import fcl_arbiter_pkg::*;

  localparam int IDX_W = $clog2(N_CFG + 1);

  logic [N_CFG-1:0] cmd_prev_q;
  logic [N_CFG-1:0] w_edge;

  // Reset to all ones so a command already held through reset does not
  // count as a press; it has to be released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_prev_q <= '1;
    end else begin
      cmd_prev_q <= cmd_i;
    end
  end

  assign w_edge = cmd_i & ~cmd_prev_q;

  // Scan from the top down so the lowest set bit is the last to write.
  always_comb begin
    edge_idx_o = IDX_W'(FCL_NO_CFG);
    for (int k = N_CFG - 1; k >= 0; k--) begin
      if (w_edge[k]) begin
        edge_idx_o = IDX_W'(k + 1);
      end
    end
  end

  assign edge_valid_o = |w_edge;

endmodule : fcl_cmd_edge_arb
`default_nettype wire

// File: rtl/fcl_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fcl_arbiter                                                  |
// | Purpose : Field-config-load controller. Arbitrates command presses,    |
// |           holds one pending request, issues a one-cycle go strobe when |
// |           loading is allowed and tracks the loader busy window.        |
// | Ports   : clk, rst - clock, synchronous active-high reset              |
// |           bus      - fcl_arbiter_if.slave (commands, loader handshake, |
// |                      go/index/busy/timeout outputs)                    |
// | Macro   : FCL_TIMEOUT_EN - abort WAIT_START after TIMEOUT_CYC cycles   |
// |           without i_is_loading and pulse o_timeout                     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module fcl_arbiter #(
  parameter int N_CFG       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  wire          clk,
  input  wire          rst,
  fcl_arbiter_if.slave bus
);
  import fcl_arbiter_pkg::*;

  localparam int IDX_W = $clog2(N_CFG + 1);

  logic             w_edge_valid;
  logic [IDX_W-1:0] w_edge_idx;

  fcl_cmd_edge_arb #(
    .N_CFG (N_CFG)
  ) u_edge_arb (
    .clk          (clk),
    .rst          (rst),
    .cmd_i        (bus.i_cmd_load_cfg),
    .edge_valid_o (w_edge_valid),
    .edge_idx_o   (w_edge_idx)
  );

  fcl_arb_state_t   state_q;
  logic [IDX_W-1:0] idx_q;
  logic             pend_valid_q;
  logic [IDX_W-1:0] pend_idx_q;
  logic             go_q;
  logic             busy_q;
  logic             timeout_q;

`ifdef FCL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= IDX_W'(FCL_NO_CFG);
      pend_valid_q <= 1'b0;
      pend_idx_q   <= IDX_W'(FCL_NO_CFG);
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef FCL_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      go_q      <= 1'b0;
      timeout_q <= 1'b0;

      // Once a go has been committed the index is frozen; later presses
      // park in the single pending slot, newest press overwriting.
      if (w_edge_valid &&
          (state_q == GO || state_q == WAIT_START || state_q == LOADING)) begin
        pend_valid_q <= 1'b1;
        pend_idx_q   <= w_edge_idx;
      end

      case (state_q)
        IDLE: begin
          if (pend_valid_q) begin
            // Pending request is served first; a press in this same cycle
            // takes over the slot it just vacated.
            state_q      <= ARMED;
            busy_q       <= 1'b1;
            idx_q        <= pend_idx_q;
            pend_valid_q <= w_edge_valid;
            pend_idx_q   <= w_edge_idx;
          end else if (w_edge_valid) begin
            state_q <= ARMED;
            busy_q  <= 1'b1;
            idx_q   <= w_edge_idx;
          end
        end

        ARMED: begin
          // Nothing issued yet, so a newer press simply retargets.
          if (w_edge_valid) begin
            idx_q <= w_edge_idx;
          end
          if (bus.i_FCL_allowed) begin
            state_q <= GO;
          end
        end

        GO: begin
          // The strobe register lags the state by one cycle, so o_go is
          // high during the first WAIT_START cycle.
          state_q <= WAIT_START;
          go_q    <= 1'b1;
`ifdef FCL_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end

        WAIT_START: begin
          if (bus.i_is_loading) begin
            state_q <= LOADING;
`ifdef FCL_TIMEOUT_EN
          end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            idx_q     <= IDX_W'(FCL_NO_CFG);
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end

        LOADING: begin
          if (!bus.i_is_loading) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= IDX_W'(FCL_NO_CFG);
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idx_q   <= IDX_W'(FCL_NO_CFG);
        end
      endcase
    end
  end

  assign bus.o_go          = go_q;
  assign bus.o_cur_cfg_idx = idx_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_timeout     = timeout_q;

endmodule : fcl_arbiter
`default_nettype wire

// File: tb/tb_fcl_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_fcl_arbiter                                               |
// | Purpose : Self-checking bench for fcl_arbiter: directed scenarios plus |
// |           randomized traffic against a transaction-level model.        |
// | Ports   : none                                                         |
// | Macro   : FCL_TIMEOUT_EN - also exercises the WAIT_START timeout       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_fcl_arbiter;

  localparam int N_CFG = 4;
  localparam int TMO   = 8;
`ifdef FCL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcl_arbiter_if #(.N_CFG(N_CFG)) bus ();

  fcl_arbiter #(
    .N_CFG       (N_CFG),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_go_seen = 0;

  // Reference model: a request's life is tracked as "selected index" plus
  // milestones (launched, go issued, loader seen) and a pending queue.
  logic [N_CFG-1:0] m_prev;
  int  m_sel;
  bit  m_busy, m_armed, m_launch, m_waiting, m_loading;
  int  m_wait;
  int  m_pend[$];
  bit  m_go, m_tmo;

  function automatic int lowest_press(input logic [N_CFG-1:0] e);
    for (int i = 0; i < N_CFG; i++) if (e[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_prev = '1; m_sel = 0; m_busy = 0; m_armed = 0; m_launch = 0;
    m_waiting = 0; m_loading = 0; m_wait = 0; m_go = 0; m_tmo = 0;
    m_pend.delete();
  endtask

  task automatic model_step(input logic [N_CFG-1:0] cmd, input bit alw, input bit ld);
    int w;
    w = lowest_press(cmd & ~m_prev);
    m_prev = cmd;
    m_go = 0; m_tmo = 0;
    if (!m_busy) begin
      if (m_pend.size() > 0) begin
        m_sel = m_pend.pop_front(); m_busy = 1; m_armed = 1;
        if (w != 0) m_pend.push_back(w);
      end else if (w != 0) begin
        m_sel = w; m_busy = 1; m_armed = 1;
      end
    end else if (m_armed) begin
      if (w != 0) m_sel = w;
      if (alw) begin m_armed = 0; m_launch = 1; end
    end else begin
      if (w != 0) begin m_pend.delete(); m_pend.push_back(w); end
      if (m_launch) begin
        m_launch = 0; m_go = 1; m_waiting = 1; m_wait = 0;
      end else if (m_waiting) begin
        if (ld) begin
          m_waiting = 0; m_loading = 1;
        end else if (TMO_EN) begin
          m_wait++;
          if (m_wait == TMO) begin
            m_waiting = 0; m_busy = 0; m_sel = 0; m_tmo = 1;
          end
        end
      end else if (m_loading && !ld) begin
        m_loading = 0; m_busy = 0; m_sel = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".go"},   32'(bus.o_go),          32'(m_go));
    check({tag, ".idx"},  32'(bus.o_cur_cfg_idx), 32'(m_sel));
    check({tag, ".busy"}, 32'(bus.o_busy),        32'(m_busy));
    check({tag, ".tmo"},  32'(bus.o_timeout),     32'(m_tmo));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cycle(input logic [N_CFG-1:0] cmd, input bit alw, input bit ld);
    bus.i_cmd_load_cfg = cmd;
    bus.i_FCL_allowed  = alw;
    bus.i_is_loading   = ld;
    @(posedge clk);
    model_step(cmd, alw, ld);
    #1;
    if (bus.o_go === 1'b1) n_go_seen++;
    check_all("cyc");
  endtask

  task automatic do_reset(input logic [N_CFG-1:0] cmd);
    rst = 1'b1;
    bus.i_cmd_load_cfg = cmd;
    bus.i_FCL_allowed  = 1'b1;
    bus.i_is_loading   = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int gos0;
    logic [N_CFG-1:0] cmd;
    bit alw, ld;

    // Bit 1 held through reset: no request until released and re-pressed.
    do_reset(4'b0010);
    repeat (3) cycle(4'b0010, 1'b1, 1'b0);
    check("held_no_req", 32'(bus.o_busy), 32'd0);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0010, 1'b1, 1'b0);             // edge at posedge k
    check("tp1_idx", 32'(bus.o_cur_cfg_idx), 32'd2);
    cycle(4'b0010, 1'b1, 1'b0);             // k+1: allowed sampled
    check("tp1_go_early", 32'(bus.o_go), 32'd0);
    cycle(4'b0010, 1'b1, 1'b0);             // k+2: strobe
    check("tp1_go", 32'(bus.o_go), 32'd1);
    cycle(4'b0010, 1'b1, 1'b1);
    check("tp1_go_once", 32'(bus.o_go), 32'd0);
    cycle(4'b0000, 1'b1, 1'b0);
    check("tp1_done", 32'(bus.o_busy), 32'd0);

    // Simultaneous presses on bits 2 and 0: lowest wins.
    cycle(4'b0101, 1'b1, 1'b0);
    check("tp2_idx", 32'(bus.o_cur_cfg_idx), 32'd1);
    cycle(4'b0101, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    repeat (3) cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b0);
    check("tp2_idx_clr", 32'(bus.o_cur_cfg_idx), 32'd0);
    check("tp2_busy_clr", 32'(bus.o_busy), 32'd0);

    // Retarget while ARMED, then exactly one go.
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b1001, 1'b0, 1'b0);
    check("tp3_idx", 32'(bus.o_cur_cfg_idx), 32'd4);
    gos0 = n_go_seen;
    repeat (3) cycle(4'b0000, 1'b1, 1'b0);
    repeat (2) cycle(4'b0000, 1'b1, 1'b1);
    repeat (3) cycle(4'b0000, 1'b1, 1'b0);
    check("tp3_one_go", 32'(n_go_seen - gos0), 32'd1);

    // Presses during LOADING land in the pending slot, newest wins.
    cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);             // go
    cycle(4'b0000, 1'b1, 1'b1);             // LOADING
    cycle(4'b0100, 1'b0, 1'b1);
    cycle(4'b1100, 1'b0, 1'b1);
    gos0 = n_go_seen;
    cycle(4'b0000, 1'b0, 1'b0);             // load ends
    check("tp4_idle", 32'(bus.o_cur_cfg_idx), 32'd0);
    cycle(4'b0000, 1'b1, 1'b0);             // re-arm from pending
    check("tp4_rearm", 32'(bus.o_cur_cfg_idx), 32'd4);
    repeat (2) cycle(4'b0000, 1'b1, 1'b0);
    check("tp4_go2", 32'(n_go_seen - gos0), 32'd1);
    cycle(4'b0000, 1'b1, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0);

`ifdef FCL_TIMEOUT_EN
    // Loader never starts: timeout TMO cycles after leaving GO.
    cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < TMO; i++) cycle(4'b0000, 1'b1, 1'b0);
    check("tmo_pulse", 32'(bus.o_timeout), 32'd1);
    check("tmo_idx", 32'(bus.o_cur_cfg_idx), 32'd0);
    cycle(4'b0000, 1'b1, 1'b0);
    check("tmo_one_cycle", 32'(bus.o_timeout), 32'd0);
    // Loader starts in the expiry cycle: load wins.
    cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < TMO - 1; i++) cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b1);
    check("tmo_race_none", 32'(bus.o_timeout), 32'd0);
    check("tmo_race_busy", 32'(bus.o_busy), 32'd1);
    cycle(4'b0000, 1'b1, 1'b0);
`endif

    // Randomized traffic against the model.
    cmd = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) cmd = cmd ^ N_CFG'(1 << $urandom_range(0, N_CFG - 1));
      alw = ($urandom_range(0, 9) < 7);
      ld  = ($urandom_range(0, 9) < 4);
      cycle(cmd, alw, ld);
    end
    repeat (4) cycle(cmd, 1'b1, 1'b0);

    // Reset during WAIT_START with a request pending: everything aborts.
    do_reset(4'b0000);
    cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);             // go, now WAIT_START
    cycle(4'b0010, 1'b1, 1'b0);             // pending press
    gos0 = n_go_seen;
    do_reset(4'b0010);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_idx", 32'(bus.o_cur_cfg_idx), 32'd0);
    for (int i = 0; i < 10; i++) cycle(4'b0010, 1'b1, (i % 3) == 1);
    check("rst_no_go", 32'(n_go_seen - gos0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fcl_arbiter
`default_nettype wire
